// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the cache read controller and its helpers.
package cache_ctrl_pkg;

  localparam int DEFAULT_NUM_WAYS   = 512;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 32;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    READ,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESP
  } state_t;

  // Way select vector at the default way count (hit/victim/target/fill).
  typedef logic [DEFAULT_NUM_WAYS-1:0] way_vec_t;

endpackage

// File: rtl/cache_read_controller_if.sv
// Bundle of CPU, tag-compare, way-reader and memory signals around the
// cache read controller. The master modport is the controller's view;
// the slave modport is the view of everything surrounding it.
interface cache_read_controller_if
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS   = DEFAULT_NUM_WAYS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
);

  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_resp_valid;
  logic                  cpu_resp_ready;
  logic [DATA_WIDTH-1:0] cpu_resp_data;
  logic                  cpu_resp_hit;
  logic                  lookup_en;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic [NUM_WAYS-1:0]   hit_vec;
  logic [NUM_WAYS-1:0]   victim_way;
  logic [NUM_WAYS-1:0]   target_way;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  logic                  fill_en;
  logic [NUM_WAYS-1:0]   fill_way;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  multi_hit_err;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  modport master (
    input  cpu_req_valid, cpu_addr, cpu_resp_ready,
    input  hit_vec, victim_way, read_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
    output lookup_en, lookup_addr, target_way,
    output mem_req_valid, fill_en, fill_way, fill_data,
    output multi_hit_err, hit_count, miss_count
  );

  modport slave (
    output cpu_req_valid, cpu_addr, cpu_resp_ready,
    output hit_vec, victim_way, read_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
    input  lookup_en, lookup_addr, target_way,
    input  mem_req_valid, fill_en, fill_way, fill_data,
    input  multi_hit_err, hit_count, miss_count
  );

endinterface

// File: rtl/lowest_set_onehot.sv
// Priority encoder: isolates the lowest-index set bit as a one-hot vector
// and flags whether any bit, or more than one bit, is set.
module lowest_set_onehot #(
  parameter int N = 8
) (
  input  logic [N-1:0] in_vec_i,
  output logic [N-1:0] onehot_o,
  output logic         any_o,
  output logic         multi_o
);

  // x & -x keeps only the lowest set bit; all-zero input yields all-zero.
  assign onehot_o = in_vec_i & (~in_vec_i + N'(1));
  assign any_o    = |in_vec_i;
  // Anything left after removing the winning bit means a second hit.
  assign multi_o  = |(in_vec_i & ~onehot_o);

endmodule

// File: rtl/cache_read_controller.sv
// Sequences one CPU read at a time: tag lookup, then either a one-cycle way
// read on a hit or a memory fetch plus one-cycle fill on a miss, then holds
// the response until the CPU takes it. Hit/miss counters saturate.
module cache_read_controller
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS   = DEFAULT_NUM_WAYS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_read_controller_if.master bus
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] lookup_addr_q, lookup_addr_d;
  logic [NUM_WAYS-1:0]   target_way_q, target_way_d;
  logic [NUM_WAYS-1:0]   fill_way_q, fill_way_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic [NUM_WAYS-1:0]   hit_onehot;
  logic                  hit_any;
  logic                  hit_multi;
  logic [NUM_WAYS-1:0]   victim_onehot;
  logic                  victim_any;
  logic                  victim_multi_unused;
  logic [NUM_WAYS-1:0]   fill_sel;

  lowest_set_onehot #(.N(NUM_WAYS)) u_hit_enc (
    .in_vec_i (bus.hit_vec),
    .onehot_o (hit_onehot),
    .any_o    (hit_any),
    .multi_o  (hit_multi)
  );

  lowest_set_onehot #(.N(NUM_WAYS)) u_victim_enc (
    .in_vec_i (bus.victim_way),
    .onehot_o (victim_onehot),
    .any_o    (victim_any),
    .multi_o  (victim_multi_unused)
  );

  // An empty victim vector falls back to way 0.
  assign fill_sel = victim_onehot | {{(NUM_WAYS-1){1'b0}}, ~victim_any};

  // Strobes are pure functions of the state so reset clears them at once.
  assign bus.cpu_req_ready  = (state_q == IDLE);
  assign bus.lookup_en      = (state_q == LOOKUP);
  assign bus.multi_hit_err  = (state_q == LOOKUP) && hit_multi;
  assign bus.mem_req_valid  = (state_q == MISS_REQ);
  assign bus.fill_en        = (state_q == FILL);
  assign bus.cpu_resp_valid = (state_q == RESP);
  assign bus.lookup_addr    = lookup_addr_q;
  assign bus.target_way     = target_way_q;
  assign bus.fill_way       = fill_way_q;
  assign bus.fill_data      = fill_data_q;
  assign bus.cpu_resp_data  = resp_data_q;
  assign bus.cpu_resp_hit   = resp_hit_q;
  assign bus.hit_count      = hit_cnt_q;
  assign bus.miss_count     = miss_cnt_q;

  // Next-state and datapath update for each sequencing step.
  always_comb begin
    state_d       = state_q;
    lookup_addr_d = lookup_addr_q;
    target_way_d  = target_way_q;
    fill_way_d    = fill_way_q;
    fill_data_d   = fill_data_q;
    resp_data_d   = resp_data_q;
    resp_hit_d    = resp_hit_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req_valid) begin
          lookup_addr_d = bus.cpu_addr;
          state_d       = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          target_way_d = hit_onehot;
          hit_cnt_d    = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_WIDTH'(1);
          state_d      = READ;
        end else begin
          fill_way_d   = fill_sel;
          miss_cnt_d   = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_WIDTH'(1);
          state_d      = MISS_REQ;
        end
      end
      READ: begin
        resp_data_d  = bus.read_data;
        resp_hit_d   = 1'b1;
        target_way_d = '0;
        state_d      = RESP;
      end
      MISS_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (bus.mem_resp_valid) begin
          fill_data_d = bus.mem_resp_data;
          resp_data_d = bus.mem_resp_data;
          resp_hit_d  = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        fill_way_d = '0;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.cpu_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lookup_addr_q <= '0;
      target_way_q  <= '0;
      fill_way_q    <= '0;
      fill_data_q   <= '0;
      resp_data_q   <= '0;
      resp_hit_q    <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      lookup_addr_q <= lookup_addr_d;
      target_way_q  <= target_way_d;
      fill_way_q    <= fill_way_d;
      fill_data_q   <= fill_data_d;
      resp_data_q   <= resp_data_d;
      resp_hit_q    <= resp_hit_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_read_controller.sv
// Self-checking bench for cache_read_controller: directed table of read
// transactions, reset-during-miss and counter saturation sequences, then
// randomized transactions checked against a behavioural model.
module tb_cache_read_controller;

  localparam int NW = 16;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_read_controller_if #(
    .NUM_WAYS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) bus ();

  cache_read_controller #(
    .NUM_WAYS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [NW-1:0] hit_vec;
    logic [NW-1:0] victim;
    logic [DW-1:0] rdata;
    logic [DW-1:0] mdata;
    int            grant_dly;
    int            resp_dly;
    int            ready_dly;
    logic          exp_hit;
    logic [NW-1:0] exp_target;
    logic [NW-1:0] exp_fill;
    logic [DW-1:0] exp_data;
    logic          exp_multi;
  } txn_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_hits   = 0;
  int m_misses = 0;
  int txn_no   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [NW-1:0] lowest(input logic [NW-1:0] v);
    for (int i = 0; i < NW; i++) begin
      if (v[i]) return NW'(1) << i;
    end
    return '0;
  endfunction

  // Reference model: expected outcome of a read from the lookup inputs.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    r.exp_hit    = (t.hit_vec != '0);
    r.exp_target = lowest(t.hit_vec);
    r.exp_multi  = ($countones(t.hit_vec) > 1);
    r.exp_fill   = (t.victim == '0) ? NW'(1) : lowest(t.victim);
    r.exp_data   = r.exp_hit ? t.rdata : t.mdata;
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_vec(input int mode);
    logic [NW-1:0] v;
    case (mode)
      0:       v = '0;
      1:       v = NW'(1) << $urandom_range(0, NW - 1);
      default: v = NW'($urandom);
    endcase
    return v;
  endfunction

  function automatic txn_t rand_txn(input bit force_hit);
    txn_t t;
    t.addr      = $urandom;
    t.hit_vec   = rand_vec(force_hit ? $urandom_range(1, 2) : $urandom_range(0, 2));
    if (force_hit && t.hit_vec == '0) t.hit_vec = NW'(1);
    t.victim    = rand_vec($urandom_range(0, 2));
    t.rdata     = $urandom;
    t.mdata     = $urandom;
    t.grant_dly = $urandom_range(0, 3);
    t.resp_dly  = $urandom_range(0, 3);
    t.ready_dly = $urandom_range(0, 3);
    return model(t);
  endfunction

  // Drive one read from IDLE to the response handshake, checking every cycle.
  task automatic run_txn(input txn_t t);
    chk("idle_req_ready", bus.cpu_req_ready, 1);
    chk("idle_resp_valid", bus.cpu_resp_valid, 0);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_addr      = t.addr;
    step();
    // Lookup cycle.
    bus.cpu_req_valid = 1'b0;
    bus.cpu_addr      = $urandom;
    bus.hit_vec       = t.hit_vec;
    bus.victim_way    = t.victim;
    #1;
    chk("lookup_en", bus.lookup_en, 1);
    chk("lookup_addr", bus.lookup_addr, t.addr);
    chk("multi_hit_err", bus.multi_hit_err, t.exp_multi);
    chk("req_ready_busy", bus.cpu_req_ready, 0);
    chk("resp_valid_lookup", bus.cpu_resp_valid, 0);
    step();
    // Lookup inputs are now don't-care; scramble them.
    bus.hit_vec    = NW'($urandom);
    bus.victim_way = NW'($urandom);
    #1;
    chk("lookup_en_off", bus.lookup_en, 0);
    chk("multi_hit_err_off", bus.multi_hit_err, 0);
    if (t.exp_hit) begin
      chk("target_way", bus.target_way, t.exp_target);
      chk("fill_en_read", bus.fill_en, 0);
      chk("mem_req_read", bus.mem_req_valid, 0);
      chk("resp_valid_read", bus.cpu_resp_valid, 0);
      bus.read_data = t.rdata;
      step();
      bus.read_data = $urandom;
    end else begin
      chk("target_way_miss", bus.target_way, 0);
      for (int g = 0; g <= t.grant_dly; g++) begin
        bus.mem_req_ready  = (g == t.grant_dly);
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        bus.mem_resp_data  = $urandom;
        #1;
        chk("mem_req_valid", bus.mem_req_valid, 1);
        chk("lookup_addr_hold", bus.lookup_addr, t.addr);
        chk("fill_en_req", bus.fill_en, 0);
        chk("resp_valid_req", bus.cpu_resp_valid, 0);
        step();
      end
      bus.mem_req_ready = 1'b0;
      for (int r = 0; r <= t.resp_dly; r++) begin
        bus.mem_resp_valid = (r == t.resp_dly);
        bus.mem_resp_data  = (r == t.resp_dly) ? t.mdata : DW'($urandom);
        #1;
        chk("mem_req_dropped", bus.mem_req_valid, 0);
        chk("fill_en_wait", bus.fill_en, 0);
        chk("resp_valid_wait", bus.cpu_resp_valid, 0);
        step();
      end
      bus.mem_resp_valid = 1'($urandom_range(0, 1));
      bus.mem_resp_data  = $urandom;
      #1;
      chk("fill_en", bus.fill_en, 1);
      chk("fill_way", bus.fill_way, t.exp_fill);
      chk("fill_data", bus.fill_data, t.mdata);
      chk("target_way_fill", bus.target_way, 0);
      chk("resp_valid_fill", bus.cpu_resp_valid, 0);
      step();
    end
    // Response phase with optional backpressure; competing requests are offered.
    for (int k = 0; k <= t.ready_dly; k++) begin
      bus.cpu_resp_ready = (k == t.ready_dly);
      bus.cpu_req_valid  = (k < t.ready_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cpu_addr       = $urandom;
      bus.mem_resp_valid = 1'($urandom_range(0, 1));
      #1;
      chk("resp_valid", bus.cpu_resp_valid, 1);
      chk("resp_data", bus.cpu_resp_data, t.exp_data);
      chk("resp_hit", bus.cpu_resp_hit, t.exp_hit);
      chk("req_ready_resp", bus.cpu_req_ready, 0);
      chk("fill_en_resp", bus.fill_en, 0);
      chk("target_way_resp", bus.target_way, 0);
      chk("fill_way_resp", bus.fill_way, 0);
      step();
    end
    bus.cpu_resp_ready = 1'b0;
    bus.cpu_req_valid  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    if (t.exp_hit) m_hits   = (m_hits   < CNT_MAX) ? m_hits + 1   : m_hits;
    else           m_misses = (m_misses < CNT_MAX) ? m_misses + 1 : m_misses;
    #1;
    chk("resp_valid_done", bus.cpu_resp_valid, 0);
    chk("req_ready_done", bus.cpu_req_ready, 1);
    chk("hit_count", bus.hit_count, m_hits);
    chk("miss_count", bus.miss_count, m_misses);
    $display("txn %0d addr=0x%08h %s data=0x%08h hits=%0d misses=%0d",
             txn_no, t.addr, t.exp_hit ? "hit " : "miss", t.exp_data, m_hits, m_misses);
    txn_no++;
  endtask

  txn_t tbl[6];

  initial begin
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_addr       = '0;
    bus.cpu_resp_ready = 1'b0;
    bus.hit_vec        = '0;
    bus.victim_way     = '0;
    bus.read_data      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;

    // Directed table: inputs and hand-derived expected outcomes.
    tbl[0] = '{addr:32'h100, hit_vec:16'h0020, victim:16'h0003, rdata:32'hDEADBEEF, mdata:32'h0,
               grant_dly:0, resp_dly:0, ready_dly:0,
               exp_hit:1, exp_target:16'h0020, exp_fill:16'h0, exp_data:32'hDEADBEEF, exp_multi:0};
    tbl[1] = '{addr:32'h200, hit_vec:16'h0000, victim:16'h0080, rdata:32'h1111, mdata:32'hCAFEF00D,
               grant_dly:2, resp_dly:2, ready_dly:0,
               exp_hit:0, exp_target:16'h0, exp_fill:16'h0080, exp_data:32'hCAFEF00D, exp_multi:0};
    tbl[2] = '{addr:32'h300, hit_vec:16'h0208, victim:16'h0001, rdata:32'h12345678, mdata:32'h0,
               grant_dly:0, resp_dly:0, ready_dly:0,
               exp_hit:1, exp_target:16'h0008, exp_fill:16'h0, exp_data:32'h12345678, exp_multi:1};
    tbl[3] = '{addr:32'h400, hit_vec:16'h8000, victim:16'h0000, rdata:32'hA5A50001, mdata:32'h0,
               grant_dly:0, resp_dly:0, ready_dly:5,
               exp_hit:1, exp_target:16'h8000, exp_fill:16'h0, exp_data:32'hA5A50001, exp_multi:0};
    tbl[4] = '{addr:32'h500, hit_vec:16'h0000, victim:16'h0000, rdata:32'h0, mdata:32'h0BADF00D,
               grant_dly:0, resp_dly:0, ready_dly:1,
               exp_hit:0, exp_target:16'h0, exp_fill:16'h0001, exp_data:32'h0BADF00D, exp_multi:0};
    tbl[5] = '{addr:32'h600, hit_vec:16'h0000, victim:16'h00C0, rdata:32'h0, mdata:32'h76543210,
               grant_dly:1, resp_dly:3, ready_dly:2,
               exp_hit:0, exp_target:16'h0, exp_fill:16'h0040, exp_data:32'h76543210, exp_multi:0};

    // Reset values while reset is held.
    #2;
    chk("rst_req_ready", bus.cpu_req_ready, 1);
    chk("rst_resp_valid", bus.cpu_resp_valid, 0);
    chk("rst_target_way", bus.target_way, 0);
    chk("rst_fill_way", bus.fill_way, 0);
    chk("rst_fill_data", bus.fill_data, 0);
    chk("rst_resp_data", bus.cpu_resp_data, 0);
    chk("rst_lookup_addr", bus.lookup_addr, 0);
    chk("rst_hit_count", bus.hit_count, 0);
    chk("rst_miss_count", bus.miss_count, 0);
    chk("rst_fill_en", bus.fill_en, 0);
    chk("rst_mem_req", bus.mem_req_valid, 0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Reset asserted asynchronously while waiting for memory data.
    bus.cpu_req_valid = 1'b1;
    bus.cpu_addr      = 32'h700;
    step();
    bus.cpu_req_valid = 1'b0;
    bus.hit_vec       = '0;
    bus.victim_way    = 16'h0010;
    #1;
    chk("rstseq_lookup_en", bus.lookup_en, 1);
    step();
    bus.mem_req_ready = 1'b1;
    #1;
    chk("rstseq_mem_req", bus.mem_req_valid, 1);
    step();
    bus.mem_req_ready = 1'b0;
    #1;
    chk("rstseq_fill_way", bus.fill_way, 16'h0010);
    #1;
    rst = 1'b1;
    #1;
    m_hits   = 0;
    m_misses = 0;
    chk("rstmid_req_ready", bus.cpu_req_ready, 1);
    chk("rstmid_mem_req", bus.mem_req_valid, 0);
    chk("rstmid_fill_en", bus.fill_en, 0);
    chk("rstmid_fill_way", bus.fill_way, 0);
    chk("rstmid_lookup_addr", bus.lookup_addr, 0);
    chk("rstmid_resp_data", bus.cpu_resp_data, 0);
    chk("rstmid_hit_count", bus.hit_count, 0);
    chk("rstmid_miss_count", bus.miss_count, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_resp_valid = (i < 2);
      bus.mem_resp_data  = 32'h55AA55AA;
      #1;
      chk("postrst_fill_en", bus.fill_en, 0);
      chk("postrst_resp_valid", bus.cpu_resp_valid, 0);
      chk("postrst_req_ready", bus.cpu_req_ready, 1);
      step();
    end
    bus.mem_resp_valid = 1'b0;

    // Drive the hit counter past its all-ones ceiling.
    for (int i = 0; i < CNT_MAX + 3; i++) run_txn(rand_txn(1'b1));
    chk("hit_count_saturated", bus.hit_count, CNT_MAX);

    // Randomized mix against the model.
    for (int i = 0; i < 40; i++) run_txn(rand_txn(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
